tdm_deframer: RTL

TDM_DEFRAMER -- requirements
Module: tdm_deframer

---
 rtl/tdm_deframer.sv | 94 +++++++++
 1 files changed

// File: rtl/tdm_deframer.sv
// tdm_deframer: serial TDM frame deframer, 4 channels x 8 bits per frame.
// Frame bits are bit-interleaved MSB first: frame bit k belongs to channel
// k mod 4 at bit position 7 - (k div 4). Bit 0 is marked by sync.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-high reset
//   x_in        - serial data bit
//   x_valid     - qualifies x_in and sync on the current edge
//   sync        - marks the accepted bit as frame bit 0
//   sel[1:0]    - channel slot of the next bit to be accepted
//   ch0..ch3    - bytes of the last completed frame
//   frame_valid - one-cycle pulse, ch0..ch3 just updated
//   sync_err    - one-cycle pulse, sync arrived mid-frame
//   locked      - high while receiving frames
//
// state | meaning
// HUNT  | waiting for the first sync, incoming bits are dropped
// RECV  | frame aligned, cnt tracks the next frame bit index

module tdm_deframer #(
  parameter int FRAME_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x_in,
  input  logic       x_valid,
  input  logic       sync,
  output logic [1:0] sel,
  output logic [7:0] ch0,
  output logic [7:0] ch1,
  output logic [7:0] ch2,
  output logic [7:0] ch3,
  output logic       frame_valid,
  output logic       sync_err,
  output logic       locked
);

  typedef enum logic {HUNT, RECV} state_t;

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_t          state;
  logic [4:0]      cnt;
  logic [3:0][7:0] sr;

  // cnt only leaves zero in RECV, so its low bits already read 0 in HUNT.
  assign sel    = cnt[1:0];
  assign locked = (state == RECV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= 5'd0;
      sr          <= '0;
      ch0         <= 8'h00;
      ch1         <= 8'h00;
      ch2         <= 8'h00;
      ch3         <= 8'h00;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (x_valid) begin
        if (state == HUNT) begin
          if (sync) begin
            sr[0] <= {sr[0][6:0], x_in};
            cnt   <= 5'd1;
            state <= RECV;
          end
        end else if (sync) begin
          // Realign on any sync; a partial frame is dropped and the stale
          // shift register contents are overwritten over the next 32 bits.
          sync_err <= (cnt != 5'd0);
          sr[0]    <= {sr[0][6:0], x_in};
          cnt      <= 5'd1;
        end else begin
          sr[cnt[1:0]] <= {sr[cnt[1:0]][6:0], x_in};
          cnt          <= cnt + 5'd1;
          if (cnt == LAST_BIT) begin
            // Bit 31 is the LSB of channel 3; fold it in directly.
            ch0         <= sr[0];
            ch1         <= sr[1];
            ch2         <= sr[2];
            ch3         <= {sr[3][6:0], x_in};
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
